// File: rtl/intt_post_scale.sv
// intt_post_scale: scales both INTT output lanes by n^-1 (Montgomery mo_mul),
//   tags the last pair of each polynomial and flags partial frames.
// Latency: L = `MUL_STAGE_CNT (+1 with INTT_POST_CANON_EN); no backpressure,
//   a pair accepted on in_en always emerges L cycles later.
// Ports: clk, rst (async, active high), in_en/in[2] (input pair stream),
//   out_en/out[2] (scaled pair stream), out_last (PAIRS-th pair of a frame),
//   busy (state != IDLE), frame_err (sticky partial-frame flag).
// Option macro: INTT_POST_CANON_EN adds a canonical-reduction stage (out < Q).

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 3
`endif

// mo_mul: r = a*b*2^-32 mod Q, built from two 16-bit Montgomery reductions.
// Latency: 3 register stages, matching `MUL_STAGE_CNT.
// Data registers are deliberately not reset; a must be < Q.
module mo_mul #(
  parameter int W  = 16,
  parameter int Q  = 3329,
  parameter int QP = 3327            // -Q^-1 mod 2^16
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);
  localparam logic [31:0] Q32  = 32'(Q);
  localparam logic [15:0] Q16  = 16'(Q);
  localparam logic [15:0] QP16 = 16'(QP);

  logic [31:0] prod_d, prod_q;
  logic [15:0] m1, m2, u2;
  logic [15:0] u1_d, u1_q;
  logic [15:0] r_d, r_q;

  always_comb begin
    prod_d = 32'(a) * 32'(b);
    // First reduction: prod < Q*2^16, so u1 < 2Q.
    m1   = prod_q[15:0] * QP16;
    u1_d = 16'((prod_q + 32'(m1) * Q32) >> 16);
    // Second reduction: u2 <= Q, one conditional subtract makes it canonical.
    m2   = u1_q * QP16;
    u2   = 16'((32'(u1_q) + 32'(m2) * Q32) >> 16);
    r_d  = (u2 >= Q16) ? u2 - Q16 : u2;
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    u1_q   <= u1_d;
    r_q    <= r_d;
  end

  assign r = W'(r_q);
endmodule

module intt_post_scale #(
  parameter logic [`DATA_WIDTH-1:0] NINV = `DATA_WIDTH'(1441),
  parameter int PAIRS = 1 << `NTT_STAGE_CNT,
  parameter int Q     = 3329
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [`DATA_WIDTH-1:0] in [2],
  output logic                   out_en,
  output logic [`DATA_WIDTH-1:0] out [2],
  output logic                   out_last,
  output logic                   busy,
  output logic                   frame_err
);
  localparam int W  = `DATA_WIDTH;
  localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
`ifdef INTT_POST_CANON_EN
  localparam int L  = `MUL_STAGE_CNT + 1;
`else
  localparam int L  = `MUL_STAGE_CNT;
`endif
  localparam logic [CW-1:0] CNT_MAX = CW'(PAIRS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_d, state_q;
  logic [CW-1:0] in_cnt_d, in_cnt_q;
  logic [L-1:0]  vld_d, vld_q;
  logic [L-1:0]  lst_d, lst_q;
  logic          frame_err_d, frame_err_q;
  logic          last_in;

  logic [W-1:0]  mul_res [2];
  logic [W-1:0]  res [2];

  always_comb begin
    last_in = in_en && (in_cnt_q == CNT_MAX);

    // Counter restarts at 0 on wrap and whenever the stream stops, so a
    // partial frame never leaks its count into the next one.
    in_cnt_d = '0;
    if (in_en && !last_in) in_cnt_d = in_cnt_q + CW'(1);

    frame_err_d = frame_err_q | (!in_en && (in_cnt_q != '0));

    vld_d = {vld_q[L-2:0], in_en};
    lst_d = {lst_q[L-2:0], last_in};

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_en) state_d = ST_RUN;
      ST_RUN:   if (!in_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (in_en) state_d = ST_RUN;
        // Look at the next pipe contents so busy drops as the last pair leaves.
        else if (vld_d == '0) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      vld_q       <= '0;
      lst_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      frame_err_q <= frame_err_d;
    end
  end

  mo_mul #(.W(W), .Q(Q)) u_mul0 (.clk(clk), .a(NINV), .b(in[0]), .r(mul_res[0]));
  mo_mul #(.W(W), .Q(Q)) u_mul1 (.clk(clk), .a(NINV), .b(in[1]), .r(mul_res[1]));

`ifdef INTT_POST_CANON_EN
  logic [W-1:0] canon_d [2];
  logic [W-1:0] canon_q [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      canon_d[k] = (mul_res[k] >= W'(Q)) ? mul_res[k] - W'(Q) : mul_res[k];
    end
  end

  always_ff @(posedge clk) begin
    canon_q <= canon_d;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) res[k] = canon_q[k];
  end
`else
  always_comb begin
    for (int k = 0; k < 2; k++) res[k] = mul_res[k];
  end
`endif

  assign out_en    = vld_q[L-1];
  assign out_last  = lst_q[L-1];
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;

  // Data regs are unreset; gating keeps out at 0 whenever nothing is valid.
  always_comb begin
    for (int k = 0; k < 2; k++) out[k] = out_en ? res[k] : '0;
  end
endmodule

// File: tb/tb_intt_post_scale.sv
// Directed bench for intt_post_scale: an identity-scaled instance (NINV=R^2 mod Q)
// checked against the input, and an NINV=1441 instance checked against a
// golden a*NINV*2^-32 mod Q model, both fed from the same in_en stream.
module tb_intt_post_scale;
  localparam int Q      = 3329;
  localparam int PAIRS  = 128;
  localparam int NINV_S = 1441;
`ifdef MUL_STAGE_CNT
  localparam int ML = `MUL_STAGE_CNT;
`else
  localparam int ML = 3;
`endif
`ifdef INTT_POST_CANON_EN
  localparam int L = ML + 1;
`else
  localparam int L = ML;
`endif

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        lst;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en = 1'b0;
  logic [15:0] din [2];
  logic [15:0] din_s [2];
  logic [15:0] dout [2];
  logic [15:0] dout_s [2];
  logic        out_en, out_last, busy, frame_err;
  logic        out_en_s, out_last_s, busy_s, frame_err_s;

  exp_t   exp_q[$];
  exp_t   exp_s[$];
  exp_t   me, ms;
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     n_out = 0;
  int     n_last = 0;
  int     fidx = 0;
  longint rinv = 0;

  intt_post_scale #(.NINV(16'd1353)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din),
    .out_en(out_en), .out(dout), .out_last(out_last),
    .busy(busy), .frame_err(frame_err)
  );

  intt_post_scale #(.NINV(16'd1441)) dut_s (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din_s),
    .out_en(out_en_s), .out(dout_s), .out_last(out_last_s),
    .busy(busy_s), .frame_err(frame_err_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // mo_mul radix is 2^32, i.e. two factors of R^-1 with R = 2^16.
  function automatic logic [15:0] gold(input logic [15:0] a);
    longint t;
    t = (longint'(a) * NINV_S) % Q;
    t = (t * rinv) % Q;
    t = (t * rinv) % Q;
    return 16'(t);
  endfunction

  task automatic drive(input logic [15:0] a0, input logic [15:0] a1);
    exp_t e, es;
    logic [15:0] s0, s1;
    s0 = 16'($urandom_range(0, Q - 1));
    s1 = 16'($urandom_range(0, Q - 1));
    @(posedge clk); #1;
    in_en = 1'b1;
    din[0] = a0;   din[1] = a1;
    din_s[0] = s0; din_s[1] = s1;
    e.d0 = a0; e.d1 = a1; e.lst = (fidx == PAIRS - 1); e.cyc = cyc;
    es.d0 = gold(s0); es.d1 = gold(s1); es.lst = e.lst; es.cyc = cyc;
    exp_q.push_back(e);
    exp_s.push_back(es);
    fidx = (fidx == PAIRS - 1) ? 0 : fidx + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_en = 1'b0;
      fidx = 0;
    end
  endtask

  task automatic settle();
    idle(L + 3);
    chk("queue_left", exp_q.size(), 0);
    chk("queue_left_s", exp_s.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_en) begin
      n_out++;
      if (out_last) n_last++;
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        me = exp_q.pop_front();
        chk("out0", dout[0], me.d0);
        chk("out1", dout[1], me.d1);
        chk("out_last", out_last, me.lst);
        chk("latency", cyc - me.cyc, L);
      end
    end else begin
      chk("last_without_en", out_last, 0);
    end
  end

  always @(negedge clk) begin
    if (out_en_s) begin
      if (exp_s.size() == 0) chk("spurious_out_s", 1, 0);
      else begin
        ms = exp_s.pop_front();
        chk("scaled0", dout_s[0], ms.d0);
        chk("scaled1", dout_s[1], ms.d1);
        chk("scaled_range", (dout_s[0] < 16'(Q)) && (dout_s[1] < 16'(Q)), 1);
        chk("out_last_s", out_last_s, ms.lst);
        chk("latency_s", cyc - ms.cyc, L);
      end
    end
  end

  initial begin
    int k;
    for (int i = 1; i < Q; i++) if ((i * (65536 % Q)) % Q == 1) rinv = i;
    din = '{16'd0, 16'd0};
    din_s = '{16'd0, 16'd0};

    // Reset state
    @(negedge clk);
    chk("rst_out_en", out_en, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out0", dout[0], 0);
    chk("rst_out1", dout[1], 0);
    @(posedge clk); #3 rst = 1'b0;
    idle(2);

    // One full frame, identity scaling of (5, 3328)
    n_out = 0; n_last = 0;
    for (int i = 0; i < PAIRS; i++) drive(16'd5, 16'd3328);
    settle();
    chk("t1_outputs", n_out, PAIRS);
    chk("t1_lasts", n_last, 1);
    chk("t1_frame_err", frame_err, 0);
    chk("t1_busy_idle", busy, 0);

    // (3328, 0) boundary values
    n_out = 0; n_last = 0;
    for (int i = 0; i < PAIRS; i++) drive(16'd3328, 16'd0);
    settle();
    chk("t5_outputs", n_out, PAIRS);

    // Two back-to-back frames, busy timing after the last input
    n_out = 0; n_last = 0;
    for (int i = 0; i < 2 * PAIRS; i++) drive(16'd0, 16'd0);
    k = cyc;
    @(posedge clk); #1;
    in_en = 1'b0;
    fidx = 0;
    do @(negedge clk); while (cyc < k + L);
    chk("t2_busy_at_last_out", busy, 1);
    @(negedge clk);
    chk("t2_busy_dropped", busy, 0);
    settle();
    chk("t2_outputs", n_out, 2 * PAIRS);
    chk("t2_lasts", n_last, 2);

    // Frame, one-cycle gap, frame: restart from DRAIN
    n_out = 0; n_last = 0;
    for (int i = 0; i < PAIRS; i++) drive(16'(i * 26), 16'(3328 - i));
    idle(1);
    drive(16'd1, 16'd2);
    chk("t6_busy_rerun", busy, 1);
    for (int i = 1; i < PAIRS; i++) drive(16'(i), 16'(Q - 1 - i));
    settle();
    chk("t6_outputs", n_out, 2 * PAIRS);
    chk("t6_lasts", n_last, 2);
    chk("t6_frame_err", frame_err, 0);

    // Partial frame of 40, then a full frame
    n_out = 0; n_last = 0;
    for (int i = 0; i < 40; i++) drive(16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1)));
    settle();
    chk("t3_frame_err_set", frame_err, 1);
    chk("t3_outputs", n_out, 40);
    chk("t3_lasts", n_last, 0);
    n_out = 0; n_last = 0;
    for (int i = 0; i < PAIRS; i++) drive(16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1)));
    settle();
    chk("t3_next_outputs", n_out, PAIRS);
    chk("t3_next_lasts", n_last, 1);
    chk("t3_frame_err_sticky", frame_err, 1);

    // Reset in the middle of a frame
    for (int i = 0; i < 60; i++) drive(16'(i), 16'(i + 7));
    #2;
    rst = 1'b1;
    in_en = 1'b0;
    fidx = 0;
    exp_q.delete();
    exp_s.delete();
    #1;
    chk("t4_out_en", out_en, 0);
    chk("t4_out_last", out_last, 0);
    chk("t4_busy", busy, 0);
    chk("t4_frame_err", frame_err, 0);
    chk("t4_out_en_s", out_en_s, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    idle(2);
    n_out = 0; n_last = 0;
    for (int i = 0; i < PAIRS; i++) drive(16'(i + 100), 16'(3000 - i));
    settle();
    chk("t4_outputs", n_out, PAIRS);
    chk("t4_lasts", n_last, 1);
    chk("t4_frame_err_clear", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
